conv_layer1_ctrl: RTL and testbench
===================================

# conv_layer1_ctrl

Sequencer for the layer-1 5x5 convolution datapath. On a start pulse it streams the input feature map from the image RAM once per output channel, driving the datapath's `ce`, `rst` and `self_rst`. It counts the datapath's valid results and writes them channel-major into the layer-1 output buffer. It sits between the top-level network FSM and the convolution/feature-map memories.

## Interface
Parameters:
- I_SIZE, 28, input feature-map side length
- K_SIZE, 5, kernel side length
- CO, 4, number of output channels to sequence
- FA_BW, 10, fmap address width; must be at least clog2(I_SIZE*I_SIZE)
- OA_BW, 12, output address width; must be at least clog2(CO*(I_SIZE-K_SIZE+1)^2)

Ports:
- clk  in  1  clock
- global_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  one-cycle start pulse; ignored unless the block is idle
- i_abort  in  1  synchronous abort
- o_fmap_rd  out  1  image RAM read enable
- o_fmap_addr  out  FA_BW  image RAM read address
- o_conv_ce  out  1  datapath clock enable
- o_conv_rst  out  1  datapath counter/pipeline clear
- o_conv_self_rst  out  1  datapath channel advance
- i_conv_valid  in  1  datapath result valid
- i_conv_end  in  1  datapath end-of-map
- o_wr_en  out  1  output buffer write enable
- o_wr_addr  out  OA_BW  output buffer write address
- o_ch  out  clog2(CO)+1  current channel index
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  sticky count-mismatch flag

## Operation
- Constants:
  - NPIX = I_SIZE*I_SIZE = 784
  - OSZ = I_SIZE-K_SIZE+1 = 24
  - NOUT = OSZ*OSZ = 576
- FSM states: IDLE, CLEAR, STREAM, DRAIN, NEXT, DONE.
- IDLE → CLEAR on i_start. In the same edge: clear o_ch, o_wr_addr and o_err.
- CLEAR (1 cycle): o_conv_rst=1. Clear pix_cnt and out_cnt. → STREAM.
- STREAM: o_fmap_rd=1 and o_fmap_addr=pix_cnt; pix_cnt increments each cycle. After the read at address NPIX-1 → DRAIN.
- DRAIN: no reads. Wait for i_conv_end=1 → NEXT.
- Write path, active in STREAM and DRAIN:
  - Each cycle with i_conv_valid=1: o_wr_en=1 and o_wr_addr=o_ch*NOUT+out_cnt, registered; out_cnt increments.
  - If i_conv_valid arrives when out_cnt==NOUT, the write is suppressed and o_err is set.
- NEXT (1 cycle):
  - o_conv_self_rst=1 and o_conv_rst=1.
  - If out_cnt≠NOUT, set o_err.
  - If o_ch==CO-1 → DONE; otherwise o_ch+1 and → CLEAR.
- DONE (1 cycle): o_done=1 → IDLE. o_ch holds CO until the next start.
- i_abort, in any state except IDLE: o_conv_rst=1 for one cycle, all enables drop, → IDLE. o_done stays 0 and o_err is unchanged.
- Arithmetic:
  - Counters are unsigned.
  - pix_cnt width is FA_BW+1, so the terminal compare against NPIX-1 cannot wrap.
  - o_wr_addr is computed as a running base (base += NOUT in NEXT) plus out_cnt. No multiplier is used.

## Timing
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- Image RAM read latency is 1 cycle. o_conv_ce is o_fmap_rd delayed by one register, so ce is aligned with the returned pixel.
- o_conv_ce therefore stays high for exactly NPIX cycles per channel, starting 1 cycle after STREAM entry.
- o_wr_en/o_wr_addr are registered: they appear 1 cycle after i_conv_valid.
- o_conv_rst and o_conv_self_rst are single-cycle pulses and never coincide with o_conv_ce=1.
- i_start pulses while o_busy=1 are ignored.
- Simultaneous events:
  - i_abort in the same cycle as i_conv_end: abort wins.
  - i_abort in the same cycle as i_conv_valid: the write is dropped.
- Minimum cycles per channel: 1 (CLEAR) + NPIX + drain + 1 (NEXT).
- Reset asserted mid-operation: all outputs return asynchronously to their reset values; no partial o_done.

## Structure
- Shared layer package/header: NPIX, OSZ, NOUT, and the FSM state encodings. Widths are taken from clog2_function.vh.
- One sub-module: conv_pix_addr_gen, containing pix_cnt, the terminal flag and o_fmap_addr.
- The FSM, write-address base/offset counter, and error logic stay in the top module.

## Test plan
- Default params, single start, ideal datapath model:
  - o_conv_ce high for 784 cycles per channel.
  - 4 self_rst pulses.
  - 2304 writes at addresses 0..2303 in order.
  - o_done one cycle after the last NEXT.
  - o_err=0.
- Model emits only 575 valids on channel 2 → o_err=1 at that channel's NEXT; the run still completes with o_done=1.
- i_start reasserted at cycle 100 of STREAM → ignored; o_ch, pix_cnt and the write sequence are unaffected.
- i_abort during channel 1 DRAIN:
  - o_conv_rst pulse, then IDLE, no o_done.
  - A following start restarts at o_ch=0, wr_addr=0.
- global_rst_n low for 1 cycle mid-STREAM:
  - All outputs 0 immediately; IDLE after release.
  - A new start produces the full nominal sequence.
- i_conv_valid and i_abort in the same cycle → no o_wr_en; FSM in IDLE next cycle.

Source files
------------

// File: rtl/conv_layer1_ctrl_pkg.sv
// Shared layer-1 constants, FSM encodings and width helpers for the conv sequencer.
// Pure declarations, no timing or flow-control behaviour of its own.
package conv_layer1_ctrl_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_NEXT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) res = res + 1;
        return res;
    endfunction

    function automatic int npix(input int i_size);
        return i_size * i_size;
    endfunction

    function automatic int osz(input int i_size, input int k_size);
        return i_size - k_size + 1;
    endfunction

    function automatic int nout(input int i_size, input int k_size);
        return osz(i_size, k_size) * osz(i_size, k_size);
    endfunction

    // Values for the default 28x28 input / 5x5 kernel configuration
    localparam int L1_NPIX = 784;
    localparam int L1_OSZ  = 24;
    localparam int L1_NOUT = 576;

endpackage

// File: rtl/conv_layer1_ctrl_pix_addr_gen.sv
// Image RAM pixel counter: address follows pix_cnt, last flag at NPIX-1.
// Zero-latency combinational address; advances only while enabled.
module conv_pix_addr_gen
    import conv_layer1_ctrl_pkg::*;
#(
    parameter int I_SIZE = 28,
    parameter int FA_BW  = 10
) (
    input  logic             clk,
    input  logic             global_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [FA_BW-1:0] o_addr,
    output logic             o_last
);

    localparam int NPIX_P = npix(I_SIZE);
    localparam logic [FA_BW:0] PIX_LAST = (FA_BW+1)'(NPIX_P - 1);

    // One extra bit so the terminal compare can never alias after a wrap
    logic [FA_BW:0] pix_cnt;

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            pix_cnt <= '0;
        end else if (i_clr) begin
            pix_cnt <= '0;
        end else if (i_en) begin
            pix_cnt <= pix_cnt + 1'b1;
        end
    end

    assign o_addr = pix_cnt[FA_BW-1:0];
    assign o_last = (pix_cnt == PIX_LAST);

endmodule

// File: rtl/conv_layer1_ctrl.sv
// Layer-1 conv sequencer: streams the fmap once per output channel and writes results channel-major.
// ce trails fmap_rd by one cycle; writes are registered one cycle after i_conv_valid; no backpressure.
module conv_layer1_ctrl
    import conv_layer1_ctrl_pkg::*;
#(
    parameter int I_SIZE = 28,
    parameter int K_SIZE = 5,
    parameter int CO     = 4,
    parameter int FA_BW  = 10,
    parameter int OA_BW  = 12
) (
    input  logic                 clk,
    input  logic                 global_rst_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    output logic                 o_fmap_rd,
    output logic [FA_BW-1:0]     o_fmap_addr,
    output logic                 o_conv_ce,
    output logic                 o_conv_rst,
    output logic                 o_conv_self_rst,
    input  logic                 i_conv_valid,
    input  logic                 i_conv_end,
    output logic                 o_wr_en,
    output logic [OA_BW-1:0]     o_wr_addr,
    output logic [clog2(CO):0]   o_ch,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    localparam int CH_BW = clog2(CO) + 1;
    localparam logic [OA_BW-1:0] NOUT_A  = OA_BW'(nout(I_SIZE, K_SIZE));
    localparam logic [CH_BW-1:0] CH_LAST = CH_BW'(CO - 1);

    logic [2:0]       state, state_nxt;
    logic [OA_BW-1:0] out_cnt;
    logic [OA_BW-1:0] wr_base;
    logic             abort_rst_q;
    logic             abort_act;
    logic             pix_last;
    logic             wr_window;

    assign abort_act       = i_abort && (state != S_IDLE);
    assign wr_window       = (state == S_STREAM) || (state == S_DRAIN);
    assign o_busy          = (state != S_IDLE);
    assign o_fmap_rd       = (state == S_STREAM) && !i_abort;
    assign o_done          = (state == S_DONE) && !i_abort;
    assign o_conv_self_rst = (state == S_NEXT) && !i_abort;
    // Abort clear is issued the cycle after, once ce has already dropped
    assign o_conv_rst      = (((state == S_CLEAR) || (state == S_NEXT)) && !i_abort) || abort_rst_q;

    conv_pix_addr_gen #(
        .I_SIZE (I_SIZE),
        .FA_BW  (FA_BW)
    ) u_pix_addr_gen (
        .clk          (clk),
        .global_rst_n (global_rst_n),
        .i_clr        (state == S_CLEAR),
        .i_en         (o_fmap_rd),
        .o_addr       (o_fmap_addr),
        .o_last       (pix_last)
    );

    always_comb begin
        state_nxt = state;
        if (abort_act) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (i_start) state_nxt = S_CLEAR;
                S_CLEAR:  state_nxt = S_STREAM;
                S_STREAM: if (pix_last) state_nxt = S_DRAIN;
                S_DRAIN:  if (i_conv_end) state_nxt = S_NEXT;
                S_NEXT:   state_nxt = (o_ch == CH_LAST) ? S_DONE : S_CLEAR;
                S_DONE:   state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state       <= S_IDLE;
            o_conv_ce   <= 1'b0;
            abort_rst_q <= 1'b0;
            o_wr_en     <= 1'b0;
            o_wr_addr   <= '0;
            o_ch        <= '0;
            o_err       <= 1'b0;
            out_cnt     <= '0;
            wr_base     <= '0;
        end else begin
            state       <= state_nxt;
            o_conv_ce   <= o_fmap_rd;
            abort_rst_q <= abort_act;
            o_wr_en     <= 1'b0;

            if ((state == S_IDLE) && i_start) begin
                o_ch      <= '0;
                o_wr_addr <= '0;
                o_err     <= 1'b0;
                wr_base   <= '0;
            end

            if (state == S_CLEAR) begin
                out_cnt <= '0;
            end

            // A result beyond the expected map size is dropped and flagged
            if (wr_window && i_conv_valid && !i_abort) begin
                if (out_cnt == NOUT_A) begin
                    o_err <= 1'b1;
                end else begin
                    o_wr_en   <= 1'b1;
                    o_wr_addr <= wr_base + out_cnt;
                    out_cnt   <= out_cnt + 1'b1;
                end
            end

            if ((state == S_NEXT) && !i_abort) begin
                if (out_cnt != NOUT_A) o_err <= 1'b1;
                o_ch    <= o_ch + 1'b1;
                wr_base <= wr_base + NOUT_A;
            end
        end
    end

endmodule

// File: tb/tb_conv_layer1_ctrl.sv
// Bench for conv_layer1_ctrl: table of full-run scenarios against an ideal datapath model,
// plus hand-written abort, reset and collision sequences.
module tb_conv_layer1_ctrl;

    localparam int NPIX = 784;
    localparam int NOUT = 576;
    localparam int NCH  = 4;

    logic        clk;
    logic        global_rst_n;
    logic        i_start;
    logic        i_abort;
    logic        o_fmap_rd;
    logic [9:0]  o_fmap_addr;
    logic        o_conv_ce;
    logic        o_conv_rst;
    logic        o_conv_self_rst;
    logic        i_conv_valid;
    logic        i_conv_end;
    logic        o_wr_en;
    logic [11:0] o_wr_addr;
    logic [2:0]  o_ch;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    conv_layer1_ctrl #(
        .I_SIZE (28),
        .K_SIZE (5),
        .CO     (4),
        .FA_BW  (10),
        .OA_BW  (12)
    ) dut (
        .clk             (clk),
        .global_rst_n    (global_rst_n),
        .i_start         (i_start),
        .i_abort         (i_abort),
        .o_fmap_rd       (o_fmap_rd),
        .o_fmap_addr     (o_fmap_addr),
        .o_conv_ce       (o_conv_ce),
        .o_conv_rst      (o_conv_rst),
        .o_conv_self_rst (o_conv_self_rst),
        .i_conv_valid    (i_conv_valid),
        .i_conv_end      (i_conv_end),
        .o_wr_en         (o_wr_en),
        .o_wr_addr       (o_wr_addr),
        .o_ch            (o_ch),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_err           (o_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Ideal datapath: one result per pixel with a full 5x5 window, end pulse after the map
    int m_cnt, m_endcd, drop_ch;
    bit m_pend;
    initial begin
        i_conv_valid = 1'b0;
        i_conv_end   = 1'b0;
        m_cnt = 0; m_endcd = 0; m_pend = 0; drop_ch = -1;
        forever begin
            @(negedge clk); #1;
            if (!global_rst_n || o_conv_rst) begin
                m_cnt = 0; m_endcd = 0; m_pend = 0;
                i_conv_valid = 1'b0;
                i_conv_end   = 1'b0;
            end else begin
                i_conv_valid = m_pend;
                m_pend = 0;
                i_conv_end = (m_endcd == 1);
                if (m_endcd > 0) m_endcd--;
                if (o_conv_ce) begin
                    int r, c, q;
                    r = m_cnt / 28;
                    c = m_cnt % 28;
                    if (r >= 4 && c >= 4) begin
                        q = (r - 4) * 24 + (c - 4);
                        m_pend = !(int'(o_ch) == drop_ch && q == NOUT - 1);
                    end
                    m_cnt++;
                    if (m_cnt == NPIX) m_endcd = 4;
                end
            end
        end
    end

    int cyc, ce_total, ce_run, ce_bad, srst_cnt, wr_cnt, bad_addr, first_addr, last_addr;
    int done_cnt, done_cyc, last_srst_cyc, overlap, err_srst, exp_ch, exp_idx;

    task automatic clr_stats();
        ce_total = 0; ce_run = 0; ce_bad = 0; srst_cnt = 0; wr_cnt = 0; bad_addr = 0;
        first_addr = -1; last_addr = -1; done_cnt = 0; done_cyc = -1; last_srst_cyc = -1;
        overlap = 0; err_srst = -1; exp_ch = 0; exp_idx = 0;
    endtask

    initial begin
        cyc = 0;
        clr_stats();
        forever begin
            @(negedge clk); #2;
            cyc++;
            if (o_conv_ce) begin
                ce_total++;
                ce_run++;
            end else if (ce_run != 0) begin
                if (ce_run != NPIX) ce_bad++;
                ce_run = 0;
            end
            if ((o_conv_rst || o_conv_self_rst) && o_conv_ce) overlap++;
            if (o_wr_en) begin
                if (wr_cnt == 0) first_addr = int'(o_wr_addr);
                if (int'(o_wr_addr) != exp_ch * NOUT + exp_idx) bad_addr++;
                last_addr = int'(o_wr_addr);
                wr_cnt++;
                exp_idx++;
            end
            if (o_conv_self_rst) begin
                srst_cnt++;
                last_srst_cyc = cyc;
                exp_ch++;
                exp_idx = 0;
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (o_err && err_srst < 0) err_srst = srst_cnt;
        end
    end

    typedef struct {
        int drop_ch;
        int restart_at;
        int exp_wr;
        int exp_err;
        int exp_err_srst;
    } vec_t;

    // Called at negedge+3; returns at negedge+3 of the cycle o_done is seen
    task automatic run_job(input int restart_at, output int ch_first, output int to);
        int stream_cyc;
        clr_stats();
        i_start = 1'b1;
        @(negedge clk); #3;
        i_start = 1'b0;
        stream_cyc = -1;
        ch_first = -1;
        to = 1;
        for (int n = 0; n < 8000; n++) begin
            @(negedge clk); #3;
            i_start = 1'b0;
            if (o_fmap_rd) begin
                if (stream_cyc < 0) begin
                    stream_cyc = 0;
                    ch_first = int'(o_ch);
                end else begin
                    stream_cyc++;
                end
            end
            if (restart_at >= 0 && stream_cyc == restart_at) i_start = 1'b1;
            if (done_cnt > 0) begin
                to = 0;
                break;
            end
        end
        i_start = 1'b0;
    endtask

    task automatic check_run(input string tag, input vec_t v, input int to, input int ch_first);
        chk($sformatf("%s timeout", tag), to, 0);
        chk($sformatf("%s ce_total", tag), ce_total, NCH * NPIX);
        chk($sformatf("%s ce_bad_runs", tag), ce_bad, 0);
        chk($sformatf("%s self_rst_cnt", tag), srst_cnt, NCH);
        chk($sformatf("%s wr_cnt", tag), wr_cnt, v.exp_wr);
        chk($sformatf("%s bad_wr_addr", tag), bad_addr, 0);
        chk($sformatf("%s first_wr_addr", tag), first_addr, 0);
        chk($sformatf("%s last_wr_addr", tag), last_addr, NCH * NOUT - 1);
        chk($sformatf("%s done_cnt", tag), done_cnt, 1);
        chk($sformatf("%s done_after_next", tag), done_cyc - last_srst_cyc, 1);
        chk($sformatf("%s err", tag), int'(o_err), v.exp_err);
        if (v.exp_err != 0) chk($sformatf("%s err_at_next", tag), err_srst, v.exp_err_srst);
        chk($sformatf("%s rst_ce_overlap", tag), overlap, 0);
        chk($sformatf("%s first_ch", tag), ch_first, 0);
        chk($sformatf("%s ch_final", tag), int'(o_ch), NCH);
    endtask

    function automatic int outs_nonzero();
        return int'({o_fmap_rd, o_fmap_addr, o_conv_ce, o_conv_rst, o_conv_self_rst,
                     o_wr_en, o_wr_addr, o_ch, o_busy, o_done, o_err} != '0);
    endfunction

    vec_t vecs [3];
    vec_t nominal;

    initial begin
        int to, ch_first, reached;

        vecs[0] = '{drop_ch: -1, restart_at: -1,  exp_wr: 2304, exp_err: 0, exp_err_srst: 0};
        vecs[1] = '{drop_ch: 2,  restart_at: -1,  exp_wr: 2303, exp_err: 1, exp_err_srst: 3};
        vecs[2] = '{drop_ch: -1, restart_at: 100, exp_wr: 2304, exp_err: 0, exp_err_srst: 0};
        nominal = vecs[0];

        global_rst_n = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        chk("reset outputs", outs_nonzero(), 0);
        global_rst_n = 1'b1;
        @(negedge clk); #3;
        chk("idle after reset", int'(o_busy), 0);

        for (int i = 0; i < 3; i++) begin
            drop_ch = vecs[i].drop_ch;
            run_job(vecs[i].restart_at, ch_first, to);
            check_run($sformatf("vec%0d", i), vecs[i], to, ch_first);
            @(negedge clk); #3;
            chk($sformatf("vec%0d idle", i), int'(o_busy), 0);
        end
        drop_ch = -1;

        // Abort while channel 1 drains
        clr_stats();
        i_start = 1'b1;
        @(negedge clk); #3;
        i_start = 1'b0;
        reached = 0;
        for (int n = 0; n < 4000 && reached < 2; n++) begin
            @(negedge clk); #3;
            if (reached == 0 && o_ch == 3'd1 && o_fmap_rd) reached = 1;
            else if (reached == 1 && !o_fmap_rd) reached = 2;
        end
        chk("abort reached drain", reached, 2);
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
        chk("abort conv_rst", int'(o_conv_rst), 1);
        chk("abort idle", int'(o_busy), 0);
        chk("abort ce", int'(o_conv_ce), 0);
        repeat (20) @(negedge clk);
        #3;
        chk("abort no done", done_cnt, 0);
        chk("abort ch held", int'(o_ch), 1);
        run_job(-1, ch_first, to);
        check_run("after_abort", nominal, to, ch_first);
        @(negedge clk); #3;

        // Reset pulse in the middle of streaming
        clr_stats();
        i_start = 1'b1;
        @(negedge clk); #3;
        i_start = 1'b0;
        reached = 0;
        for (int n = 0; n < 200 && reached < 50; n++) begin
            @(negedge clk); #3;
            if (o_fmap_rd) reached++;
        end
        chk("rst reached stream", reached, 50);
        global_rst_n = 1'b0;
        #1;
        chk("async reset outputs", outs_nonzero(), 0);
        @(negedge clk); #3;
        global_rst_n = 1'b1;
        @(negedge clk); #3;
        chk("idle after mid reset", int'(o_busy), 0);
        chk("no done after mid reset", done_cnt, 0);
        run_job(-1, ch_first, to);
        check_run("after_reset", nominal, to, ch_first);
        @(negedge clk); #3;

        // Result valid and abort in the same cycle
        clr_stats();
        i_start = 1'b1;
        @(negedge clk); #3;
        i_start = 1'b0;
        reached = 0;
        for (int n = 0; n < 1000 && reached == 0; n++) begin
            @(negedge clk); #3;
            if (i_conv_valid) reached = 1;
        end
        chk("collide saw valid", reached, 1);
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
        chk("collide wr_en", int'(o_wr_en), 0);
        chk("collide idle", int'(o_busy), 0);
        chk("collide ce", int'(o_conv_ce), 0);
        @(negedge clk); #3;
        chk("collide no done", done_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
